// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the load/store to AXI-Lite bridge
package mem_pkg;

  // Access size as encoded on req_size; encoding 3 is illegal and treated as misaligned
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/mem_axil_master_if.sv
// rtl/mem_axil_master_if.sv - AXI-Lite channel bundle between the bridge and the SDRAM subsystem
interface mem_axil_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);

  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;

  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;

  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;

  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;

  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering, strobe generation, load extension and misalign check
module mem_lane_align
  import mem_pkg::*;
(
  // store side, driven from the live request
  input  logic [1:0]  st_addr_lo,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misalign,
  // load side, driven from the registered request
  input  logic [1:0]  ld_addr_lo,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [15:0] lane;

  // Replicate store data into every lane so the strobe alone selects the target bytes
  always_comb begin
    wdata    = st_data;
    wstrb    = 4'b1111;
    misalign = 1'b0;
    case (mem_size_t'(st_size))
      MEM_BYTE: begin
        wdata = {4{st_data[7:0]}};
        wstrb = 4'b0001 << st_addr_lo;
      end
      MEM_HALF: begin
        wdata    = {2{st_data[15:0]}};
        wstrb    = 4'b0011 << st_addr_lo;
        misalign = st_addr_lo[0];
      end
      MEM_WORD: misalign = (st_addr_lo != 2'b00);
      default:  misalign = 1'b1;
    endcase
  end

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it
  always_comb begin
    lane    = 16'(rdata >> {ld_addr_lo, 3'b000});
    ld_data = rdata;
    case (mem_size_t'(ld_size))
      MEM_BYTE: ld_data = {{24{~ld_unsigned & lane[7]}}, lane[7:0]};
      MEM_HALF: ld_data = {{16{~ld_unsigned & lane[15]}}, lane[15:0]};
      default:  ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_axil_master.sv
// rtl/mem_axil_master.sv - single-outstanding load/store port to AXI-Lite master bridge
module mem_axil_master
  import mem_pkg::*;
#(
  parameter int         C_AXI_DATA_WIDTH = 32,
  parameter int         C_AXI_ADDR_WIDTH = 16,
  parameter logic [2:0] AXI_PROT         = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  mem_axil_master_if.master m_axi
);

  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int SW = C_AXI_DATA_WIDTH / 8;

  state_t                      state_q, state_d;
  logic [AW-1:0]               addr_q;
  logic                        we_q;
  logic [1:0]                  size_q;
  logic                        unsigned_q;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]               wstrb_q;
  logic                        awvalid_q, wvalid_q;
  logic [31:0]                 rdata_q;
  logic                        err_q;

  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_wstrb;
  logic        misalign;
  logic        aw_done, w_done;

  // Address bits above the AXI window are dropped on purpose
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, req_addr[31:AW]};

  mem_lane_align u_align (
    .st_addr_lo (req_addr[1:0]),
    .st_size    (req_size),
    .st_data    (req_wdata),
    .wdata      (st_wdata),
    .wstrb      (st_wstrb),
    .misalign   (misalign),
    .ld_addr_lo (addr_q[1:0]),
    .ld_size    (size_q),
    .ld_unsigned(unsigned_q),
    .rdata      (m_axi.rdata),
    .ld_data    (ld_data)
  );

  // A write channel counts as done once it has handshaken or does so this cycle
  assign aw_done = !awvalid_q || m_axi.awready;
  assign w_done  = !wvalid_q  || m_axi.wready;

  assign m_axi.awvalid = awvalid_q;
  assign m_axi.awaddr  = {addr_q[AW-1:2], 2'b00};
  assign m_axi.awprot  = AXI_PROT;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.araddr  = {addr_q[AW-1:2], 2'b00};
  assign m_axi.arprot  = AXI_PROT;
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and state-decoded handshake outputs
  always_comb begin
    state_d       = state_q;
    req_ready     = (state_q == IDLE);
    m_axi.arvalid = (state_q == RADDR);
    m_axi.bready  = (state_q == WRESP);
    m_axi.rready  = (state_q == RDATA);
    resp_valid    = (state_q == RESP);
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misalign)    state_d = RESP;
          else if (req_we) state_d = WRITE;
          else             state_d = RADDR;
        end
      end
      WRITE:   if (aw_done && w_done) state_d = WRESP;
      WRESP:   if (m_axi.bvalid)      state_d = RESP;
      RADDR:   if (m_axi.arready)     state_d = RDATA;
      RDATA:   if (m_axi.rvalid)      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, write-channel valids and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr[AW-1:0];
            we_q       <= req_we;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            wdata_q    <= st_wdata;
            wstrb_q    <= st_wstrb;
            awvalid_q  <= req_we && !misalign;
            wvalid_q   <= req_we && !misalign;
            rdata_q    <= '0;
            err_q      <= misalign;
          end
        end
        WRITE: begin
          if (m_axi.awready) awvalid_q <= 1'b0;
          if (m_axi.wready)  wvalid_q  <= 1'b0;
        end
        WRESP: if (m_axi.bvalid) err_q <= (m_axi.bresp != AXI_RESP_OKAY);
        RDATA: begin
          if (m_axi.rvalid) begin
            rdata_q <= we_q ? 32'h0 : ld_data;
            err_q   <= (m_axi.rresp != AXI_RESP_OKAY);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_axil_master.sv
// tb/tb_mem_axil_master.sv - directed self-checking bench for the load/store AXI-Lite bridge
module tb_mem_axil_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  always #5 clk = ~clk;

  mem_axil_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) axi ();

  mem_axil_master #(
    .C_AXI_DATA_WIDTH(32),
    .C_AXI_ADDR_WIDTH(16),
    .AXI_PROT        (3'b000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .m_axi       (axi)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // slave behaviour knobs
  int          aw_wait = 0, w_wait = 0, r_wait = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;

  // slave state
  bit aw_seen, w_seen, ar_seen;
  bit aw_hs_p, w_hs_p, b_hs_p, ar_hs_p, r_hs_p;
  int aw_cnt, w_cnt, r_cnt;

  // observation
  int          aw_hi, w_hi, ar_hi, resp_cnt, unstable;
  logic [15:0] cap_awaddr, cap_araddr, p_awaddr;
  logic [31:0] cap_wdata, p_wdata;
  logic [3:0]  cap_wstrb;
  bit          p_awvalid, p_awready, p_wvalid, p_wready;

  // result of the last run_req
  int          got_lat;
  logic [31:0] got_rdata;
  logic        got_err;

  // AXI-Lite slave model plus channel monitor, all evaluated on the falling edge
  initial begin
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.arready = 0; axi.rvalid = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0;
        aw_hs_p = 0; w_hs_p = 0; b_hs_p = 0; ar_hs_p = 0; r_hs_p = 0;
        aw_cnt = 0; w_cnt = 0; r_cnt = 0;
        p_awvalid = 0; p_wvalid = 0;
      end else begin
        if (aw_hs_p) aw_seen = 1;
        if (w_hs_p)  w_seen = 1;
        if (ar_hs_p) ar_seen = 1;
        if (b_hs_p) begin axi.bvalid = 0; aw_seen = 0; w_seen = 0; aw_cnt = 0; w_cnt = 0; end
        if (r_hs_p) begin axi.rvalid = 0; ar_seen = 0; r_cnt = 0; end
        if (p_awvalid && !p_awready && (axi.awvalid !== 1'b1 || axi.awaddr !== p_awaddr)) unstable++;
        if (p_wvalid && !p_wready && (axi.wvalid !== 1'b1 || axi.wdata !== p_wdata)) unstable++;
        axi.awready = 0;
        if (axi.awvalid && !aw_seen) begin
          if (aw_cnt >= aw_wait) axi.awready = 1; else aw_cnt++;
        end
        axi.wready = 0;
        if (axi.wvalid && !w_seen) begin
          if (w_cnt >= w_wait) axi.wready = 1; else w_cnt++;
        end
        axi.arready = axi.arvalid && !ar_seen;
        if (aw_seen && w_seen && !axi.bvalid) begin axi.bvalid = 1; axi.bresp = cfg_bresp; end
        if (ar_seen && !axi.rvalid) begin
          if (r_cnt >= r_wait) begin axi.rvalid = 1; axi.rdata = cfg_rdata; axi.rresp = cfg_rresp; end
          else r_cnt++;
        end
        if (axi.awvalid) aw_hi++;
        if (axi.wvalid)  w_hi++;
        if (axi.arvalid) ar_hi++;
        if (resp_valid)  resp_cnt++;
        if (axi.awvalid && axi.awready) cap_awaddr = axi.awaddr;
        if (axi.wvalid && axi.wready) begin cap_wdata = axi.wdata; cap_wstrb = axi.wstrb; end
        if (axi.arvalid && axi.arready) cap_araddr = axi.araddr;
        aw_hs_p = axi.awvalid && axi.awready;
        w_hs_p  = axi.wvalid && axi.wready;
        b_hs_p  = axi.bvalid && axi.bready;
        ar_hs_p = axi.arvalid && axi.arready;
        r_hs_p  = axi.rvalid && axi.rready;
        p_awvalid = axi.awvalid; p_awready = axi.awready; p_awaddr = axi.awaddr;
        p_wvalid  = axi.wvalid;  p_wready  = axi.wready;  p_wdata  = axi.wdata;
      end
    end
  end

  task automatic clear_obs();
    aw_hi = 0; w_hi = 0; ar_hi = 0; resp_cnt = 0; unstable = 0;
  endtask

  // Present one request (acceptance edge = cycle 0) and wait for its response
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    req_valid = 1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    @(negedge clk);
    req_valid = 0;
    got_lat = 1;
    while (!resp_valid && got_lat < 100) begin @(negedge clk); got_lat++; end
    got_rdata = resp_rdata;
    got_err   = resp_err;
  endtask

  task automatic test_reset();
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_cmp++;
    if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_cmp++;
    if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
    n_cmp++;
    if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    n_cmp++;
    if ({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready} !== 5'b0) begin
      n_bad++; $display("FAIL reset_axi_ctrl: got %b want 00000",
                        {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready});
    end
    n_cmp++;
  endtask

  task automatic test_word_store();
    clear_obs();
    run_req(1'b1, 32'h0000_0104, 2'd2, 1'b0, 32'hDEAD_BEEF);
    if (got_lat !== 3) begin n_bad++; $display("FAIL wstore_latency: got %0d want 3", got_lat); end
    n_cmp++;
    if (cap_awaddr !== 16'h0104) begin n_bad++; $display("FAIL wstore_awaddr: got %h want 0104", cap_awaddr); end
    n_cmp++;
    if (cap_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wstore_wdata: got %h want deadbeef", cap_wdata); end
    n_cmp++;
    if (cap_wstrb !== 4'hF) begin n_bad++; $display("FAIL wstore_wstrb: got %h want f", cap_wstrb); end
    n_cmp++;
    if (got_err !== 1'b0 || got_rdata !== 32'h0) begin
      n_bad++; $display("FAIL wstore_resp: got err=%b rdata=%h want err=0 rdata=0", got_err, got_rdata);
    end
    n_cmp++;
  endtask

  task automatic test_byte_access();
    run_req(1'b1, 32'h0000_0106, 2'd0, 1'b0, 32'h0000_00A5);
    if (cap_wdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL bstore_wdata: got %h want a5a5a5a5", cap_wdata); end
    n_cmp++;
    if (cap_wstrb !== 4'b0100) begin n_bad++; $display("FAIL bstore_wstrb: got %b want 0100", cap_wstrb); end
    n_cmp++;
    cfg_rdata = 32'h00A5_0000;
    run_req(1'b0, 32'h0000_0106, 2'd0, 1'b0, 32'h0);
    if (got_lat !== 3) begin n_bad++; $display("FAIL bload_latency: got %0d want 3", got_lat); end
    n_cmp++;
    if (cap_araddr !== 16'h0104) begin n_bad++; $display("FAIL bload_araddr: got %h want 0104", cap_araddr); end
    n_cmp++;
    if (got_rdata !== 32'hFFFF_FFA5) begin n_bad++; $display("FAIL bload_signed: got %h want ffffffa5", got_rdata); end
    n_cmp++;
    run_req(1'b0, 32'h0000_0106, 2'd0, 1'b1, 32'h0);
    if (got_rdata !== 32'h0000_00A5) begin n_bad++; $display("FAIL bload_unsigned: got %h want 000000a5", got_rdata); end
    n_cmp++;
  endtask

  task automatic test_half_load();
    cfg_rdata = 32'h8001_0000;
    run_req(1'b0, 32'h0000_0102, 2'd1, 1'b0, 32'h0);
    if (got_rdata !== 32'hFFFF_8001) begin n_bad++; $display("FAIL hload_signed: got %h want ffff8001", got_rdata); end
    n_cmp++;
    run_req(1'b0, 32'h0000_0102, 2'd1, 1'b1, 32'h0);
    if (got_rdata !== 32'h0000_8001) begin n_bad++; $display("FAIL hload_unsigned: got %h want 00008001", got_rdata); end
    n_cmp++;
    if (got_err !== 1'b0) begin n_bad++; $display("FAIL hload_err: got %b want 0", got_err); end
    n_cmp++;
  endtask

  task automatic test_misaligned();
    clear_obs();
    run_req(1'b0, 32'h0000_0101, 2'd2, 1'b0, 32'h0);
    if (got_lat !== 1 || got_err !== 1'b1 || got_rdata !== 32'h0) begin
      n_bad++; $display("FAIL mis_wload: got lat=%0d err=%b rdata=%h want lat=1 err=1 rdata=0",
                        got_lat, got_err, got_rdata);
    end
    n_cmp++;
    run_req(1'b1, 32'h0000_0003, 2'd1, 1'b0, 32'h0000_1234);
    if (got_lat !== 1 || got_err !== 1'b1 || got_rdata !== 32'h0) begin
      n_bad++; $display("FAIL mis_hstore: got lat=%0d err=%b rdata=%h want lat=1 err=1 rdata=0",
                        got_lat, got_err, got_rdata);
    end
    n_cmp++;
    repeat (2) @(negedge clk);
    if (aw_hi !== 0 || ar_hi !== 0) begin
      n_bad++; $display("FAIL mis_no_axi: got aw_cycles=%0d ar_cycles=%0d want 0 0", aw_hi, ar_hi);
    end
    n_cmp++;
    if (resp_cnt !== 2) begin n_bad++; $display("FAIL mis_resp_count: got %0d want 2", resp_cnt); end
    n_cmp++;
  endtask

  task automatic test_write_stall();
    clear_obs();
    aw_wait = 5; w_wait = 0; cfg_bresp = 2'b00;
    run_req(1'b1, 32'h0000_0200, 2'd2, 1'b0, 32'h1122_3344);
    repeat (2) @(negedge clk);
    if (aw_hi !== 6 || w_hi !== 1) begin
      n_bad++; $display("FAIL stall_aw_first: got aw_cycles=%0d w_cycles=%0d want 6 1", aw_hi, w_hi);
    end
    n_cmp++;
    if (resp_cnt !== 1 || got_err !== 1'b0) begin
      n_bad++; $display("FAIL stall_aw_resp: got count=%0d err=%b want 1 0", resp_cnt, got_err);
    end
    n_cmp++;
    clear_obs();
    aw_wait = 0; w_wait = 5; cfg_bresp = 2'b10;
    run_req(1'b1, 32'h0000_0204, 2'd2, 1'b0, 32'h5566_7788);
    repeat (2) @(negedge clk);
    if (aw_hi !== 1 || w_hi !== 6) begin
      n_bad++; $display("FAIL stall_w_first: got aw_cycles=%0d w_cycles=%0d want 1 6", aw_hi, w_hi);
    end
    n_cmp++;
    if (resp_cnt !== 1 || got_err !== 1'b1) begin
      n_bad++; $display("FAIL stall_bresp_err: got count=%0d err=%b want 1 1", resp_cnt, got_err);
    end
    n_cmp++;
    if (cap_wdata !== 32'h5566_7788 || cap_awaddr !== 16'h0204) begin
      n_bad++; $display("FAIL stall_payload: got addr=%h data=%h want 0204 55667788", cap_awaddr, cap_wdata);
    end
    n_cmp++;
    if (unstable !== 0) begin n_bad++; $display("FAIL stall_stability: got %0d want 0", unstable); end
    n_cmp++;
    w_wait = 0; cfg_bresp = 2'b00;
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    r_wait = 10;
    @(negedge clk);
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    req_valid = 1; req_we = 0; req_addr = 32'h0000_0108; req_size = 2'd2; req_unsigned = 0;
    @(negedge clk);
    req_valid = 0;
    guard = 0;
    while (!axi.rready && guard < 20) begin @(negedge clk); guard++; end
    if (axi.rready !== 1'b1) begin n_bad++; $display("FAIL midrst_reach_rdata: got %b want 1", axi.rready); end
    n_cmp++;
    rst_n = 0;
    @(posedge clk);
    #1;
    if ({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, resp_valid} !== 6'b0) begin
      n_bad++; $display("FAIL midrst_ctrl: got %b want 000000",
                        {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, resp_valid});
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_req_ready: got %b want 1", req_ready); end
    n_cmp++;
    @(negedge clk);
    #1;
    rst_n = 1;
    r_wait = 0;
    cfg_rdata = 32'h1234_5678;
    clear_obs();
    run_req(1'b0, 32'h0000_0108, 2'd2, 1'b1, 32'h0);
    if (got_lat !== 3 || got_rdata !== 32'h1234_5678 || got_err !== 1'b0) begin
      n_bad++; $display("FAIL midrst_reload: got lat=%0d rdata=%h err=%b want 3 12345678 0",
                        got_lat, got_rdata, got_err);
    end
    n_cmp++;
    repeat (2) @(negedge clk);
    if (resp_cnt !== 1) begin n_bad++; $display("FAIL midrst_resp_count: got %0d want 1", resp_cnt); end
    n_cmp++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    #1;
    rst_n = 1;
    test_word_store();
    test_byte_access();
    test_half_load();
    test_misaligned();
    test_write_stall();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_axil_master.md
Name: mem_axil_master

Overview:
- Upstream bridge between the core's load/store port and the AXI-Lite slave port of the SDRAM AXI-Lite subsystem.
- Accepts one byte, half or word access at a time and runs the matching AXI-Lite write or read transaction.
- Performs byte-lane steering, wstrb generation and load sign/zero extension.
- Returns one response per request, flagging misaligned accesses and bus errors.

Parameters:
- C_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_AXI_ADDR_WIDTH, 16, AXI address width; req_addr is truncated to this width.
- AXI_PROT, 3'b000, constant driven on awprot/arprot.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  bridge can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  mem_size_t: 0 = byte, 1 = half, 2 = word
- req_unsigned  in  1  zero-extend the load result
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  single-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misaligned access or non-OKAY bus response
- m_axi_awvalid / awready / awaddr[C_AXI_ADDR_WIDTH] / awprot[3]  AXI-Lite AW, master side
- m_axi_wvalid / wready / wdata[32] / wstrb[4]  AXI-Lite W, master side
- m_axi_bvalid / bready / bresp[2]  AXI-Lite B, master side
- m_axi_arvalid / arready / araddr[C_AXI_ADDR_WIDTH] / arprot[3]  AXI-Lite AR, master side
- m_axi_rvalid / rready / rdata[32] / rresp[2]  AXI-Lite R, master side

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - All valids, bready, rready, resp_valid and resp_err go to 0.
  - resp_rdata goes to 0.
  - The request register is cleared.
- Reset mid-transaction abandons the transaction with no response. The downstream slave shares this reset.
- Request handshake:
  - The request is taken when req_valid && req_ready.
  - addr, we, size, unsigned and the steered wdata/wstrb are registered.
  - Only one request is outstanding at a time.
- Misalignment rule: half with addr[0] = 1, or word with addr[1:0] != 0, or size = 3.
  - The state moves to RESP.
  - Next cycle: resp_valid = 1, resp_err = 1, resp_rdata = 0.
  - No AXI traffic is issued.
- AXI address: awaddr/araddr = {req_addr[C_AXI_ADDR_WIDTH-1:2], 2'b00}.
- Store steering:
  - wdata = req_wdata replicated per lane: byte → {4{b}}, half → {2{h}}, word → as-is.
  - wstrb: byte → 4'b0001 << addr[1:0]; half → 4'b0011 << addr[1:0]; word → 4'b1111.
- States: IDLE, WRITE, WRESP, RADDR, RDATA, RESP.
- IDLE:
  - On an aligned store, go to WRITE and raise awvalid and wvalid together.
  - On an aligned load, go to RADDR and raise arvalid.
- WRITE:
  - awvalid drops on the cycle after an awready handshake; wvalid drops independently on its own handshake.
  - Either channel may complete first or both may complete in the same cycle.
  - When both are done, go to WRESP with bready = 1.
  - Valid and payload stay stable until accepted.
- WRESP: on bvalid, capture err = (bresp != 2'b00) and go to RESP.
- RADDR: hold arvalid until arready, then go to RDATA with rready = 1.
- RDATA:
  - On rvalid, select lane rdata >> (8*addr[1:0]).
  - Extend to 32 bits: sign-extend unless req_unsigned; word passes through unchanged.
  - Capture err = (rresp != 2'b00); go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, then return to IDLE.
  - req_ready rises in the cycle after RESP.
- Minimum latency: request accepted at cycle 0, zero-wait slave, resp_valid at cycle 3 for both loads and stores.
- Latency is unbounded by slave stalls. No timeout.
- On a bus error, resp_rdata still carries the extended lane data. The core decides how to handle the fault.

Decomposition:
- Package mem_pkg holds:
  - mem_size_t enum (MEM_BYTE, MEM_HALF, MEM_WORD)
  - the FSM state enum
  - AXI_RESP_OKAY = 2'b00
- One sub-module, mem_lane_align, is purely combinational. It provides:
  - store replication and wstrb generation
  - load lane select and extension
  - the misalign flag
- The FSM and the AXI channel registers stay in mem_axil_master.

Test Plan:
- Word store addr 0x0000_0104, data 0xDEADBEEF, slave with zero wait → awaddr = 0x0104, wdata = 0xDEADBEEF, wstrb = 4'hF; resp_valid at cycle 3 with err = 0.
- Byte store addr 0x0106, data 0x0000_00A5 → wdata = 0xA5A5A5A5, wstrb = 4'b0100; then signed byte load from 0x0106 with rdata = 0x00A50000 → resp_rdata = 0xFFFFFFA5; unsigned load of the same → 0x000000A5.
- Half load addr 0x0102, rdata = 0x80010000 → signed result 0xFFFF8001, unsigned 0x00008001.
- Misaligned word load at 0x0101 and half store at 0x0003 → resp_err = 1 one cycle after acceptance; no awvalid or arvalid ever asserted.
- Slave holds awready low 5 cycles with wready immediate, then the reverse ordering → wvalid drops after one cycle, awvalid stays stable; a single response follows bvalid; bresp = 2'b10 → resp_err = 1.
- Assert rst_n = 0 for one cycle while in RDATA → next cycle all valids, bready/rready and resp_valid = 0, req_ready = 1; a new load then completes normally.
